// File: rtl/tensor_issue_sched.sv
// tensor_issue_sched: per-warp matrix op holder that splits each op into THREAD_N column passes, round-robin issued.
module tensor_issue_sched #(
  parameter int NUM_WARPS     = 8,
  parameter int THREAD_N      = 4,
  parameter int NUM_TILE_BUFS = 2,
  parameter int NUM_REGS      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM_WARPS)-1:0] in_wid,
  input  logic [1:0]                   in_op,
  input  logic [$clog2(NUM_REGS)-1:0]  in_rd,
  output logic                         fire_valid,
  input  logic                         fire_ready,
  output logic [$clog2(NUM_WARPS)-1:0] fire_wid,
  output logic [$clog2(THREAD_N)-1:0]  fire_col,
  output logic                         fire_last,
  output logic                         fire_acc_buf,
  output logic                         fire_to_reg,
  output logic [$clog2(NUM_REGS)-1:0]  fire_dst,
  output logic [NUM_WARPS-1:0]         busy
);
  localparam int WW  = $clog2(NUM_WARPS);
  localparam int CW  = $clog2(THREAD_N);
  localparam int RW  = $clog2(NUM_REGS);
  localparam int WPB = NUM_WARPS / NUM_TILE_BUFS;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t        state   [NUM_WARPS];
  state_t        state_n [NUM_WARPS];
  logic [1:0]    op_q    [NUM_WARPS];
  logic [RW-1:0] rd_q    [NUM_WARPS];
  logic [CW-1:0] col_q   [NUM_WARPS];
  logic [CW-1:0] col_n   [NUM_WARPS];
  logic [WW-1:0] ptr, hold_wid, pick, grant;
  logic          hold_q, any_active, fire, accept;
  assign in_ready = state[in_wid] == IDLE;
  assign accept   = in_valid && in_ready;
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) busy[w] = state[w] == ACTIVE;
    any_active = |busy;
    pick = ptr;
    // scan farthest to nearest so the nearest active warp at or after ptr wins
    for (int i = NUM_WARPS - 1; i >= 0; i--)
      if (state[WW'(ptr + WW'(i))] == ACTIVE) pick = WW'(ptr + WW'(i));
    grant = hold_q ? hold_wid : pick;
    fire  = any_active && fire_ready;
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_n[w] = state[w];
      col_n[w]   = col_q[w];
      if (fire && grant == WW'(w)) begin
        if (col_q[w] == CW'(THREAD_N - 1)) state_n[w] = IDLE;
        else col_n[w] = col_q[w] + CW'(1);
      end
      if (accept && in_wid == WW'(w)) begin
        state_n[w] = ACTIVE;
        col_n[w]   = '0;
      end
    end
  end
  always_comb begin
    fire_valid   = any_active;
    fire_wid     = any_active ? grant : '0;
    fire_col     = any_active ? col_q[grant] : '0;
    fire_last    = any_active && col_q[grant] == CW'(THREAD_N - 1);
    fire_acc_buf = any_active && !op_q[grant][1];
    fire_to_reg  = any_active && !op_q[grant][0];
    fire_dst     = !any_active ? '0 :
                   fire_to_reg ? RW'(rd_q[grant] + RW'(col_q[grant])) :
                   RW'(int'(col_q[grant]) * NUM_TILE_BUFS + int'(grant) / WPB);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      hold_q   <= 1'b0;
      hold_wid <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        state[w] <= IDLE;
        col_q[w] <= '0;
        op_q[w]  <= '0;
        rd_q[w]  <= '0;
      end
    end else begin
      ptr      <= fire ? WW'(grant + WW'(1)) : ptr;
      hold_q   <= any_active && !fire_ready;
      hold_wid <= grant;
      for (int w = 0; w < NUM_WARPS; w++) begin
        state[w] <= state_n[w];
        col_q[w] <= col_n[w];
        if (accept && in_wid == WW'(w)) begin
          op_q[w] <= in_op;
          rd_q[w] <= in_rd;
        end
      end
    end
  end
endmodule

// File: tb/tb_tensor_issue_sched.sv
// tb_tensor_issue_sched: randomized and directed checks of the issue scheduler against a queue-free behavioural model.
module tb_tensor_issue_sched;
  localparam int NW = 8, TN = 4, NTB = 2, NR = 32;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, in_ready, fire_ready = 0;
  logic [2:0] in_wid = 0;
  logic [1:0] in_op = 0;
  logic [4:0] in_rd = 0;
  logic       fire_valid, fire_last, fire_acc_buf, fire_to_reg;
  logic [2:0] fire_wid;
  logic [1:0] fire_col;
  logic [4:0] fire_dst;
  logic [7:0] busy;
  int total = 0, bad = 0;
  bit m_active [NW];
  int m_col [NW], m_op [NW], m_rd [NW];
  int m_ptr, m_hold_wid;
  bit m_hold;
  logic [22:0] obs, exp_v;

  tensor_issue_sched #(.NUM_WARPS(NW), .THREAD_N(TN), .NUM_TILE_BUFS(NTB), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
    .in_op(in_op), .in_rd(in_rd), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_wid(fire_wid), .fire_col(fire_col), .fire_last(fire_last), .fire_acc_buf(fire_acc_buf),
    .fire_to_reg(fire_to_reg), .fire_dst(fire_dst), .busy(busy));

  always #5 clk = ~clk;
  assign obs = {fire_valid, fire_wid, fire_col, fire_last, fire_acc_buf, fire_to_reg, fire_dst, busy, in_ready};

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) begin m_active[i] = 0; m_col[i] = 0; m_op[i] = 0; m_rd[i] = 0; end
    m_ptr = 0; m_hold = 0; m_hold_wid = 0;
  endfunction

  function automatic bit model_any();
    for (int i = 0; i < NW; i++) if (m_active[i]) return 1;
    return 0;
  endfunction

  function automatic int model_grant();
    if (m_hold) return m_hold_wid;
    for (int i = 0; i < NW; i++) if (m_active[(m_ptr + i) % NW]) return (m_ptr + i) % NW;
    return 0;
  endfunction

  function automatic logic [22:0] model_out();
    logic [7:0] b;
    int g, dst;
    bit to_reg, acc;
    for (int i = 0; i < NW; i++) b[i] = m_active[i];
    if (!model_any()) return {14'd0, b, !m_active[in_wid]};
    g = model_grant();
    to_reg = m_op[g] == 0 || m_op[g] == 2;
    acc = m_op[g] < 2;
    dst = to_reg ? (m_rd[g] + m_col[g]) % NR : m_col[g] * NTB + g / (NW / NTB);
    return {1'b1, 3'(g), 2'(m_col[g]), m_col[g] == TN - 1, acc, to_reg, 5'(dst), b, !m_active[in_wid]};
  endfunction

  function automatic void model_step();
    int g;
    bit acc_ok;
    acc_ok = in_valid && !m_active[in_wid];
    if (model_any()) begin
      g = model_grant();
      if (fire_ready) begin
        if (m_col[g] == TN - 1) m_active[g] = 0;
        else m_col[g]++;
        m_ptr = (g + 1) % NW;
        m_hold = 0;
      end else begin
        m_hold = 1; m_hold_wid = g;
      end
    end else m_hold = 0;
    if (acc_ok) begin
      m_active[in_wid] = 1; m_col[in_wid] = 0; m_op[in_wid] = in_op; m_rd[in_wid] = in_rd;
    end
  endfunction

  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic offer(input bit v, input int w, input int op, input int rd);
    in_valid = v; in_wid = 3'(w); in_op = 2'(op); in_rd = 5'(rd);
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    advance();
    @(negedge clk);
    total++;
    if (obs !== {14'd0, 8'd0, 1'b1}) begin bad++; $display("FAIL reset obs=%h req=%h", obs, {14'd0, 8'd0, 1'b1}); end
    rst_n = 1;
    advance();
  endtask

  task automatic test_single();
    fire_ready = 1;
    for (int c = 0; c < 7; c++) begin
      offer(c == 0, 3, 2, 10);
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL single c=%0d obs=%h req=%h", c, obs, exp_v); end
      if (c >= 1 && c <= 4) begin
        total++;
        if (fire_dst !== 5'(9 + c) || fire_col !== 2'(c - 1) || fire_last !== (c == 4)) begin
          bad++; $display("FAIL single_dst c=%0d dst=%0d col=%0d last=%b", c, fire_dst, fire_col, fire_last);
        end
      end
      advance();
    end
  endtask

  task automatic test_pair();
    fire_ready = 0;
    for (int c = 0; c < 12; c++) begin
      offer(c < 2, c == 0 ? 0 : 5, 1, 7);
      fire_ready = c >= 2;
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL pair c=%0d obs=%h req=%h", c, obs, exp_v); end
      if (fire_valid && fire_wid == 5 && fire_col == 2) begin
        total++;
        if (fire_dst !== 5'd5) begin bad++; $display("FAIL pair_buf_dst obs=%0d req=5", fire_dst); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [22:0] held;
    for (int c = 0; c < 16; c++) begin
      offer(c == 0 || c == 3, c == 0 ? 2 : 1, 3, 4);
      fire_ready = c >= 6;
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL bp c=%0d obs=%h req=%h", c, obs, exp_v); end
      if (c == 1) held = obs[22:9];
      if (c >= 2 && c <= 6) begin
        total++;
        if (obs[22:9] !== held) begin bad++; $display("FAIL bp_stable c=%0d obs=%h req=%h", c, obs[22:9], held); end
      end
      advance();
    end
  endtask

  task automatic test_reaccept();
    fire_ready = 1;
    for (int c = 0; c < 12; c++) begin
      offer(c <= 5, 4, 0, 20);
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reaccept c=%0d obs=%h req=%h", c, obs, exp_v); end
      if (c >= 1 && c <= 5) begin
        total++;
        if (in_ready !== (c == 5)) begin bad++; $display("FAIL reaccept_ready c=%0d obs=%b req=%b", c, in_ready, c == 5); end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    fire_ready = 1;
    for (int c = 0; c < 4; c++) begin
      offer(c == 0, 6, 2, 1);
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL arst c=%0d obs=%h req=%h", c, obs, exp_v); end
      if (c < 3) advance();
    end
    #1 rst_n = 0; model_reset();
    #1 total++;
    if (fire_valid !== 1'b0 || busy !== 8'd0) begin bad++; $display("FAIL arst_now fv=%b busy=%h req fv=0 busy=00", fire_valid, busy); end
    advance();
    #2 rst_n = 1;
    for (int c = 0; c < 7; c++) begin
      offer(c == 0, 6, 2, 1);
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL arst_restart c=%0d obs=%h req=%h", c, obs, exp_v); end
      advance();
    end
  endtask

  task automatic test_rd_wrap();
    fire_ready = 1;
    for (int c = 0; c < 6; c++) begin
      offer(c == 0, 1, 0, 30);
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL wrap c=%0d obs=%h req=%h", c, obs, exp_v); end
      if (c >= 1 && c <= 4) begin
        total++;
        if (fire_dst !== 5'((29 + c) % 32)) begin bad++; $display("FAIL wrap_dst c=%0d obs=%0d req=%0d", c, fire_dst, (29 + c) % 32); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if (c < 440) begin
        offer($urandom_range(1, 0) == 1, $urandom_range(NW - 1, 0), $urandom_range(3, 0), $urandom_range(NR - 1, 0));
        fire_ready = $urandom_range(9, 0) < 7;
      end else begin
        offer(0, 0, 0, 0); fire_ready = 1;
      end
      @(negedge clk); exp_v = model_out(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random c=%0d obs=%h req=%h", c, obs, exp_v); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_backpressure();
    test_reaccept();
    test_async_reset();
    test_rd_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
